// File: rtl/pipe_pkg.sv
// Shared types for the EXE->MWB stage boundary of the three-stage core.
// The payload and control bundles are packed so the generic stage register
// can carry them as flat vectors; widths are derived from the structs.
package pipe_pkg;

    // Control bundle forwarded from EXE to MWB.
    typedef struct packed {
        logic       reg_we;    // register file write enable
        logic [1:0] dmem_sel;  // data memory access select
        logic [2:0] load_sel;  // load width / sign select
        logic [1:0] wb_sel;    // write-back source select
    } exe_mwb_ctrl_t;

    // Payload forwarded from EXE to MWB.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_result;
        logic [31:0] imm;
        logic [31:0] pc;
    } exe_mwb_data_t;

    localparam int EXE_MWB_CTRL_W = $bits(exe_mwb_ctrl_t);
    localparam int EXE_MWB_DATA_W = $bits(exe_mwb_data_t);

    // Control value carried by a bubble: no side effects downstream.
    localparam logic [EXE_MWB_CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with a two-entry skid buffer.
// The main entry drives the outputs; the skid entry catches the one extra
// beat that upstream may launch while in_ready is still high during a stall.
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high (in_fire on the input side, out_fire on the output side). Valid and
// the payload stay stable until accepted. in_ready is a flop, so ready never
// depends combinationally on out_ready. flush discards everything regardless
// of the handshake; rst has priority over flush.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 128,
    parameter int                CTRL_W   = 8,
    parameter logic [DATA_W-1:0] RST_DATA = '0,
    parameter int                CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Bubble control value widened/narrowed to this instance's ctrl width.
    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_W'(CTRL_NOP);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q,  main_ctrl_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;
    logic              in_ready_q,   in_ready_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic              in_fire;
    logic              out_fire;

    // Next-state of main/skid entries: flush, then advance/refill, then skid capture.
    always_comb begin
        in_fire      = in_valid && in_ready_q;
        out_fire     = main_valid_q && out_ready;
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = RST_DATA;
            main_ctrl_d  = CTRL_BUBBLE;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // Main is free this cycle: oldest held entry moves up first.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_ctrl_d  = skid_ctrl_q;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end
            end else if (in_fire) begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
                main_ctrl_d  = in_ctrl;
            end else begin
                // Data is left as-is; ctrl must read as a bubble.
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_BUBBLE;
            end
        end else if (in_fire) begin
            // Main stalled and full: the beat already in flight lands in skid.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_ctrl_d  = in_ctrl;
        end

        in_ready_d = !skid_valid_d;
    end

    // Saturating count of cycles where downstream was ready but got no entry.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (out_ready && !main_valid_q && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Entry registers and registered in_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RST_DATA;
            main_ctrl_q  <= CTRL_BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Bubble counter register; only rst clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign out_data   = main_data_q;
    assign out_ctrl   = main_ctrl_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus a randomized run checked
// against a FIFO model of at most two entries.
module tb_pipe_stage_skid;

    localparam int                DATA_W   = 128;
    localparam int                CTRL_W   = 8;
    localparam int                CNT_W    = 16;
    localparam int                CNT_W_S  = 2;
    localparam logic [DATA_W-1:0] RST_DATA = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;

    // Second instance only used for counter saturation at a small width.
    logic              in_ready_s;
    logic              out_valid_s;
    logic [DATA_W-1:0] out_data_s;
    logic [CTRL_W-1:0] out_ctrl_s;
    logic [CNT_W_S-1:0] bubble_cnt_s;

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboard: expected entries held by the stage, oldest first.
    logic [DATA_W-1:0] exp_q[$];
    logic [CTRL_W-1:0] exp_c[$];
    logic [CNT_W-1:0]  exp_cnt;

    pipe_stage_skid #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RST_DATA(RST_DATA), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .bubble_cnt(bubble_cnt)
    );

    pipe_stage_skid #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RST_DATA(RST_DATA), .CNT_W(CNT_W_S)
    ) dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_ctrl(out_ctrl_s),
        .bubble_cnt(bubble_cnt_s)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got=%0b exp=0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got=%0b exp=1", in_ready);
        end
        tests_run++;
        if (out_data !== RST_DATA) begin
            tests_failed++;
            $display("FAIL reset_out_data got=%0h exp=%0h", out_data, RST_DATA);
        end
        tests_run++;
        if (out_ctrl !== '0) begin
            tests_failed++;
            $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl);
        end
        tests_run++;
        if (bubble_cnt !== '0) begin
            tests_failed++;
            $display("FAIL reset_bubble_cnt got=%0d exp=0", bubble_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming();
        apply_reset();
        out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(k);
            in_ctrl  = CTRL_W'(k + 8'h10);
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || out_ctrl !== CTRL_W'(k + 8'h10)) begin
                tests_failed++;
                $display("FAIL stream_beat%0d got v=%0b d=%0h c=%0h exp v=1 d=%0h c=%0h",
                         k, out_valid, out_data, out_ctrl, k, k + 8'h10);
            end
            tests_run++;
            if (in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL stream_in_ready%0d got=%0b exp=1", k, in_ready);
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== '0) begin
            tests_failed++;
            $display("FAIL stream_drain got v=%0b c=%0h exp v=0 c=0", out_valid, out_ctrl);
        end
    endtask

    task automatic test_stall_skid();
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(128'hA); in_ctrl = 8'hA1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(128'hA) || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_a got v=%0b d=%0h r=%0b exp v=1 d=a r=1", out_valid, out_data, in_ready);
        end
        in_data = DATA_W'(128'hB); in_ctrl = 8'hB2;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== DATA_W'(128'hA) || out_ctrl !== 8'hA1) begin
            tests_failed++;
            $display("FAIL stall_skid_full got r=%0b d=%0h c=%0h exp r=0 d=a c=a1", in_ready, out_data, out_ctrl);
        end
        // C offered while in_ready is low: must not be taken yet.
        in_data = DATA_W'(128'hC); in_ctrl = 8'hC3;
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== DATA_W'(128'hA) || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_hold got r=%0b v=%0b d=%0h exp r=0 v=1 d=a", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(128'hB) || out_ctrl !== 8'hB2 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_release_b got v=%0b d=%0h c=%0h r=%0b exp v=1 d=b c=b2 r=1",
                     out_valid, out_data, out_ctrl, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(128'hC) || out_ctrl !== 8'hC3) begin
            tests_failed++;
            $display("FAIL stall_release_c got v=%0b d=%0h c=%0h exp v=1 d=c c=c3", out_valid, out_data, out_ctrl);
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_no_dup got v=%0b d=%0h exp v=0", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        logic [CNT_W-1:0] cnt_before;
        apply_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(128'hA); in_ctrl = 8'h11;
        step();
        in_data   = DATA_W'(128'hB); in_ctrl = 8'h22;
        step();
        cnt_before = bubble_cnt;
        flush   = 1'b1;
        in_data = DATA_W'(128'hD); in_ctrl = 8'h44;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== RST_DATA) begin
            tests_failed++;
            $display("FAIL flush_clear got v=%0b c=%0h d=%0h exp v=0 c=0 d=%0h",
                     out_valid, out_ctrl, out_data, RST_DATA);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_in_ready got=%0b exp=1", in_ready);
        end
        tests_run++;
        if (bubble_cnt !== cnt_before) begin
            tests_failed++;
            $display("FAIL flush_bubble_cnt got=%0d exp=%0d", bubble_cnt, cnt_before);
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_d_lost got v=%0b d=%0h exp v=0", out_valid, out_data);
        end
    endtask

    task automatic test_bubble_count();
        apply_reset();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        step();
        tests_run++;
        if (bubble_cnt !== 16'd2 || bubble_cnt_s !== 2'd2) begin
            tests_failed++;
            $display("FAIL bubble_2 got=%0d/%0d exp=2/2", bubble_cnt, bubble_cnt_s);
        end
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (bubble_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL bubble_5 got=%0d exp=5", bubble_cnt);
        end
        step();
        tests_run++;
        if (bubble_cnt !== 16'd6 || bubble_cnt_s !== 2'd3) begin
            tests_failed++;
            $display("FAIL bubble_sat got=%0d/%0d exp=6/3", bubble_cnt, bubble_cnt_s);
        end
        // Stalled with an entry present: no bubbles counted.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DATA_W'(128'h55);
        step();
        in_valid = 1'b0;
        step();
        tests_run++;
        if (bubble_cnt !== 16'd6) begin
            tests_failed++;
            $display("FAIL bubble_stall got=%0d exp=6", bubble_cnt);
        end
    endtask

    task automatic test_random();
        logic pop_ok;
        logic push_ok;
        logic [CTRL_W-1:0] exp_ctrl;
        apply_reset();
        exp_q.delete();
        exp_c.delete();
        exp_cnt = '0;
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            in_ctrl   = CTRL_W'($urandom_range(1, 255));

            // Model: at most two held entries; ready means room for another.
            if (out_ready && exp_q.size() == 0 && exp_cnt != {CNT_W{1'b1}}) exp_cnt++;
            if (flush) begin
                exp_q.delete();
                exp_c.delete();
            end else begin
                pop_ok  = (exp_q.size() > 0) && out_ready;
                push_ok = in_valid && (exp_q.size() < 2);
                if (pop_ok) begin
                    void'(exp_q.pop_front());
                    void'(exp_c.pop_front());
                end
                if (push_ok) begin
                    exp_q.push_back(in_data);
                    exp_c.push_back(in_ctrl);
                end
            end
            step();

            exp_ctrl = (exp_c.size() > 0) ? exp_c[0] : '0;
            tests_run++;
            if (out_valid !== (exp_q.size() > 0)) begin
                tests_failed++;
                $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", i, out_valid, exp_q.size() > 0);
            end
            tests_run++;
            if (in_ready !== (exp_q.size() < 2)) begin
                tests_failed++;
                $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", i, in_ready, exp_q.size() < 2);
            end
            tests_run++;
            if (out_ctrl !== exp_ctrl) begin
                tests_failed++;
                $display("FAIL rand_out_ctrl cyc=%0d got=%0h exp=%0h", i, out_ctrl, exp_ctrl);
            end
            if (exp_q.size() > 0) begin
                tests_run++;
                if (out_data !== exp_q[0]) begin
                    tests_failed++;
                    $display("FAIL rand_out_data cyc=%0d got=%0h exp=%0h", i, out_data, exp_q[0]);
                end
            end
            tests_run++;
            if (bubble_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL rand_bubble_cnt cyc=%0d got=%0d exp=%0d", i, bubble_cnt, exp_cnt);
            end
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush();
        test_bubble_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register for the three-stage RISC-V core, replacing fixed per-boundary registers such as the EXE→MWB latch. It carries an opaque data payload plus a control bundle across a stage boundary with a valid/ready handshake, stall support, flush-to-bubble, and a two-entry skid buffer so `in_ready` is registered. A saturating bubble counter supports performance debug.

## Interface
- `DATA_W`, 128: payload width (instruction, ALU result, immediate, PC packed).
- `CTRL_W`, 8: control width (reg WE, DMEM sel, LOAD sel, WB sel); forced to zero in bubbles.
- `RST_DATA`, 0: `DATA_W`-bit value of `out_data` after reset/flush.
- `CNT_W`, 16: bubble counter width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flush`  in  1  discard all held entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept this cycle; registered.
- `in_data`  in  `DATA_W`  payload.
- `in_ctrl`  in  `CTRL_W`  control bundle.
- `out_valid`  out  1  main entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  `DATA_W`  main entry payload.
- `out_ctrl`  out  `CTRL_W`  main entry ctrl; 0 when `out_valid`=0.
- `bubble_cnt`  out  `CNT_W`  saturating count of bubble cycles.

## Operation
- Two entries: main (drives outputs) and skid. `in_ready` = !skid_valid.
- in_fire = `in_valid` & `in_ready`; out_fire = `out_valid` & `out_ready`.
- Main empty or out_fire: main loads skid if skid_valid (skid empties; in_fire in the same cycle writes skid), else loads input on in_fire, else goes invalid.
- Main full, no out_fire, in_fire: input goes to skid.
- Stall (main full, `out_ready`=0): main and skid hold data and ctrl unchanged.
- Order strictly FIFO; no entry dropped or duplicated except by flush/rst.
- `flush`: next edge clears both valids, main data ← `RST_DATA`, main ctrl ← 0; in_fire that cycle is dropped. `flush` overrides all handshakes.
- `bubble_cnt` increments when `out_ready`=1 and `out_valid`=0; saturates at all-ones; cleared only by `rst`, not by `flush`.
- Priority: `rst` > `flush` > handshake.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `out_data`=`RST_DATA`, `out_ctrl`=0, `bubble_cnt`=0, skid empty.
- Latency input→output: 1 cycle when empty. Throughput 1 entry/cycle with `out_ready` held high.
- `in_ready` falls the cycle after skid fills; rises the cycle after skid drains. Upstream may see in_ready=1 while main is full; skid absorbs exactly one extra entry.
- `out_valid`, `out_data`, `out_ctrl`, `in_ready` are register outputs; no combinational path from `out_ready` to `in_ready`.
- `flush` or `rst` during a stall: next cycle `out_valid`=0, `in_ready`=1.
- Simultaneous in_fire and out_fire with skid empty: main replaced by new entry, no bubble.

## Structure
- Shared package `pipe_pkg`: EXE→MWB payload/ctrl packed-struct typedefs and their widths, plus `CTRL_NOP`=0 constant.
- No sub-module needed; skid and main are two instances of the same register logic inline. Counter may be a local `sat_counter` sub-module if one already exists in the package.

## Test plan
- Reset: `rst`=1 two cycles → `out_valid`=0, `in_ready`=1, `out_data`=`RST_DATA`, `out_ctrl`=0, `bubble_cnt`=0.
- Streaming: 8 entries data=1..8, `out_ready`=1 → outputs 1..8 on consecutive cycles, 1-cycle latency, `in_ready` stays 1.
- Stall/skid: `out_ready`=0 after entry A, send B, C → B in skid, `in_ready`=0 next cycle, C not accepted; release → A, B, C in order.
- Flush: main=A, skid=B, `flush`=1 with `in_valid`=1 data D → next cycle `out_valid`=0, `out_ctrl`=0, D lost; `bubble_cnt` unchanged by flush.
- Bubble count: `out_ready`=1, `in_valid`=0 for 5 cycles → `bubble_cnt`=5; with `CNT_W`=2, 6 cycles → 3 (saturated).
- Random: random `in_valid`/`out_ready`/sparse `flush` vs. reference FIFO model; ctrl zero whenever `out_valid`=0.
